// File: rtl/adder_ctrl_pkg.sv
// Shared types and defaults for the adder accumulate controller.
package adder_ctrl_pkg;

  localparam int unsigned WIDTH_DEF    = 16;
  localparam int unsigned CNT_W_DEF    = 8;
  localparam logic        SYNC_RST_VAL = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/button_sync.sv
// Two-stage synchronizer for a raw button, with level and rising-edge outputs.
module button_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Resetting every stage high means a button held through reset gives no edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_prev <= RST_VAL;
    end else begin
      r_meta <= i_btn;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_prev;

endmodule

// File: rtl/adder_accum_ctrl.sv
// Button-driven accumulate controller around an external WIDTH-bit adder.
// Optional subtract mode is enabled by defining ADDER_SUB_EN.
module adder_accum_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             Load,
  input  logic             ClearA,
  input  logic [WIDTH-1:0] SW,
`ifdef ADDER_SUB_EN
  input  logic             Sub,
`endif
  input  logic [WIDTH-1:0] Add_S,
  input  logic             Add_Cout,
  output logic [WIDTH-1:0] Add_A,
  output logic [WIDTH-1:0] Add_B,
  output logic             Add_Cin,
  output logic [WIDTH-1:0] Acc,
  output logic [WIDTH-1:0] Breg,
  output logic             Cout,
  output logic             Ovf,
  output logic [CNT_W-1:0] AddCount,
  output logic             Busy
);

  state_e            r_state;
  state_e            w_next;
  logic [WIDTH-1:0]  r_acc;
  logic [WIDTH-1:0]  r_breg;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_cout;
  logic              r_ovf;
  logic              w_busy;
  logic              w_sub_act;
  logic              w_ovf;
  logic              w_run_lvl, w_run_rise;
  logic              w_load_lvl, w_load_rise;
  logic              w_clr_lvl, w_clr_rise;
  logic              w_unused_rise;

  button_sync #(.RST_VAL(SYNC_RST_VAL)) u_sync_run (
    .i_clk  (Clk),
    .i_rst  (Reset),
    .i_btn  (Run),
    .o_level(w_run_lvl),
    .o_rise (w_run_rise)
  );

  button_sync #(.RST_VAL(SYNC_RST_VAL)) u_sync_load (
    .i_clk  (Clk),
    .i_rst  (Reset),
    .i_btn  (Load),
    .o_level(w_load_lvl),
    .o_rise (w_load_rise)
  );

  button_sync #(.RST_VAL(SYNC_RST_VAL)) u_sync_clr (
    .i_clk  (Clk),
    .i_rst  (Reset),
    .i_btn  (ClearA),
    .o_level(w_clr_lvl),
    .o_rise (w_clr_rise)
  );

  assign w_unused_rise = w_load_rise ^ w_clr_rise;

`ifdef ADDER_SUB_EN
  logic r_mode;

  // Mode is latched only on the IDLE->ADD transition so it cannot change mid-add.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_mode <= 1'b0;
    end else if (r_state == IDLE && w_run_rise) begin
      r_mode <= Sub;
    end
  end

  assign w_sub_act = (r_state == ADD) && r_mode;
`else
  assign w_sub_act = 1'b0;
`endif

  assign Add_A   = r_acc;
  assign Add_B   = w_sub_act ? ~r_breg : r_breg;
  assign Add_Cin = w_sub_act;
  assign w_ovf   = (Add_A[WIDTH-1] == Add_B[WIDTH-1]) && (Add_S[WIDTH-1] != Add_A[WIDTH-1]);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_run_rise) w_next = ADD;
      ADD:     w_next = HOLD;
      HOLD:    if (!w_run_lvl) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state == ADD);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_acc  <= '0;
      r_breg <= '0;
      r_cnt  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // A Run edge wins; Load/ClearA re-act next cycle if still held.
          if (!w_run_rise) begin
            if (w_load_lvl) r_breg <= SW;
            if (w_clr_lvl) begin
              r_acc <= '0;
              r_cnt <= '0;
            end
          end
        end
        ADD: begin
          r_acc  <= Add_S;
          r_cout <= Add_Cout;
          r_ovf  <= w_ovf;
          r_cnt  <= r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign Acc      = r_acc;
  assign Breg     = r_breg;
  assign Cout     = r_cout;
  assign Ovf      = r_ovf;
  assign AddCount = r_cnt;
  assign Busy     = w_busy;

endmodule

// File: tb/tb_adder_accum_ctrl.sv
// Directed bench for adder_accum_ctrl with a per-cycle reference model.
module tb_adder_accum_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        load = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] sw = 16'h0000;
`ifdef ADDER_SUB_EN
  logic        sub = 1'b0;
`endif
  logic [15:0] add_s;
  logic        add_cout;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic        add_cin;
  logic [15:0] acc;
  logic [15:0] breg;
  logic        cout;
  logic        ovf;
  logic [7:0]  cnt;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  adder_accum_ctrl #(.WIDTH(16), .CNT_W(8)) dut (
    .Clk     (clk),
    .Reset   (rst),
    .Run     (run),
    .Load    (load),
    .ClearA  (clr),
    .SW      (sw),
`ifdef ADDER_SUB_EN
    .Sub     (sub),
`endif
    .Add_S   (add_s),
    .Add_Cout(add_cout),
    .Add_A   (add_a),
    .Add_B   (add_b),
    .Add_Cin (add_cin),
    .Acc     (acc),
    .Breg    (breg),
    .Cout    (cout),
    .Ovf     (ovf),
    .AddCount(cnt),
    .Busy    (busy)
  );

  // External adder
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {16'h0000, add_cin};

  always #5 clk = ~clk;

  // Reference model: buttons seen two edges late, one add per press.
  int m_acc = 0, m_b = 0, m_cnt = 0, m_phase = 0; // phase: 0 idle, 1 adding, 2 waiting release
  bit m_cout = 0, m_ovf = 0, m_mode = 0;
  bit rh[1:3] = '{1, 1, 1};
  bit lh[1:3] = '{1, 1, 1};
  bit ch[1:3] = '{1, 1, 1};

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int effb, cin, full, sa, sb, sres;
    bit run_now, run_before, load_now, clr_now;
    if (rst) begin
      m_acc = 0; m_b = 0; m_cnt = 0; m_phase = 0;
      m_cout = 0; m_ovf = 0; m_mode = 0;
      rh = '{1, 1, 1}; lh = '{1, 1, 1}; ch = '{1, 1, 1};
      return;
    end
    run_now = rh[2]; run_before = rh[3]; load_now = lh[2]; clr_now = ch[2];
    case (m_phase)
      0: begin
        if (run_now && !run_before) begin
          m_phase = 1;
`ifdef ADDER_SUB_EN
          m_mode = sub;
`else
          m_mode = 0;
`endif
        end else begin
          if (load_now) m_b = int'(sw);
          if (clr_now) begin
            m_acc = 0;
            m_cnt = 0;
          end
        end
      end
      1: begin
        effb = m_mode ? (65535 - m_b) : m_b;
        cin  = m_mode ? 1 : 0;
        full = m_acc + effb + cin;
        sa   = (m_acc >= 32768) ? m_acc - 65536 : m_acc;
        sb   = (effb >= 32768) ? effb - 65536 : effb;
        sres = sa + sb + cin;
        m_acc  = full % 65536;
        m_cout = (full > 65535);
        m_ovf  = (sres > 32767) || (sres < -32768);
        m_cnt  = (m_cnt + 1) % 256;
        m_phase = 2;
      end
      default: if (!run_now) m_phase = 0;
    endcase
    rh[3] = rh[2]; rh[2] = rh[1]; rh[1] = run;
    lh[3] = lh[2]; lh[2] = lh[1]; lh[1] = load;
    ch[3] = ch[2]; ch[2] = ch[1]; ch[1] = clr;
  endtask

  always begin
    int exp_b;
    @(posedge clk);
    model_step();
    #1;
    exp_b = (m_phase == 1 && m_mode) ? (65535 - m_b) : m_b;
    check("acc", int'(acc), m_acc);
    check("breg", int'(breg), m_b);
    check("addcount", int'(cnt), m_cnt);
    check("busy", int'(busy), (m_phase == 1) ? 1 : 0);
    check("cout", int'(cout), int'(m_cout));
    check("ovf", int'(ovf), int'(m_ovf));
    check("add_a", int'(add_a), m_acc);
    check("add_b", int'(add_b), exp_b);
    check("add_cin", int'(add_cin), (m_phase == 1 && m_mode) ? 1 : 0);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int hold);
    run = 1'b1;
    cyc(hold);
    run = 1'b0;
    cyc(5);
  endtask

  task automatic do_load(input logic [15:0] v);
    sw = v;
    load = 1'b1;
    cyc(4);
    load = 1'b0;
    cyc(3);
  endtask

  task automatic do_clear();
    clr = 1'b1;
    cyc(4);
    clr = 1'b0;
    cyc(3);
  endtask

  initial begin
    cyc(3);
    check("rst_acc", int'(acc), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_addb", int'(add_b), 0);
    rst = 1'b0;
    cyc(3);

    // Load 1, clear, three presses, then one long press
    do_load(16'h0001);
    do_clear();
    repeat (3) press(4);
    check("x3_acc", int'(acc), 16'h0003);
    check("x3_cnt", int'(cnt), 3);
    press(50);
    check("long_acc", int'(acc), 16'h0004);
    check("long_cnt", int'(cnt), 4);

    // Signed overflow and unsigned carry
    do_clear();
    do_load(16'h7FFF);
    press(4);
    do_load(16'h0001);
    press(4);
    check("ovf_acc", int'(acc), 16'h8000);
    check("ovf_ovf", int'(ovf), 1);
    check("ovf_cout", int'(cout), 0);
    do_clear();
    do_load(16'hFFFF);
    press(4);
    do_load(16'h0001);
    press(4);
    check("carry_acc", int'(acc), 16'h0000);
    check("carry_cout", int'(cout), 1);
    check("carry_ovf", int'(ovf), 0);

    // Asynchronous reset in the middle of an add
    do_clear();
    do_load(16'h1234);
    press(4);
    check("pre_rst_acc", int'(acc), 16'h1234);
    run = 1'b1;
    cyc(3);
    check("mid_add_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    check("async_acc", int'(acc), 0);
    check("async_busy", int'(busy), 0);
    check("async_cnt", int'(cnt), 0);
    check("async_breg", int'(breg), 0);
    cyc(2);
    rst = 1'b0;
    // Run still held through release: no add
    cyc(10);
    check("held_cnt", int'(cnt), 0);
    check("held_busy", int'(busy), 0);
    run = 1'b0;
    cyc(5);
    run = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("lat_busy_early", int'(busy), 0);
    end
    @(posedge clk);
    #1;
    check("lat_busy_3", int'(busy), 1);
    cyc(3);
    run = 1'b0;
    cyc(5);
    check("after_rst_cnt", int'(cnt), 1);

    // Run edge and Load synced together: add wins, Load acts after HOLD exits
    do_load(16'h0002);
    do_clear();
    sw = 16'h00FF;
    run = 1'b1;
    load = 1'b1;
    cyc(4);
    check("race_acc", int'(acc), 16'h0002);
    check("race_breg_hold", int'(breg), 16'h0002);
    run = 1'b0;
    cyc(6);
    check("race_breg_after", int'(breg), 16'h00FF);
    load = 1'b0;
    cyc(3);

`ifdef ADDER_SUB_EN
    do_clear();
    do_load(16'h0005);
    press(4);
    do_load(16'h0007);
    sub = 1'b1;
    press(4);
    sub = 1'b0;
    check("sub_acc", int'(acc), 16'hFFFE);
    check("sub_cout", int'(cout), 0);
    check("sub_ovf", int'(ovf), 0);
`endif

    // Counter wrap
    do_clear();
    repeat (255) begin
      run = 1'b1;
      cyc(3);
      run = 1'b0;
      cyc(4);
    end
    check("wrap_ff", int'(cnt), 8'hFF);
    press(3);
    check("wrap_00", int'(cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adder_accum_ctrl.md
# adder_accum_ctrl

Sequential control and accumulate stage for the 16-bit adder datapath. It synchronizes the board's Run/Load/ClearA buttons, registers operand B from the switches, and drives the adder's A, B and carry-in inputs. The accumulator is register A. On each Run press it consumes the adder's sum and carry-out once and writes the sum back into A. The block sits between the switch/button inputs and the hex-display drivers.

## Interface
- WIDTH, 16: datapath width; must match the adder instance.
- CNT_W, 8: width of the add counter.
- Clk  in  1  system clock; all state is updated on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Run  in  1  raw, unsynchronized button level (active-high); a rising edge requests one add.
- Load  in  1  raw button level (active-high); copies SW into B.
- ClearA  in  1  raw button level (active-high); clears the accumulator and counter.
- SW  in  WIDTH  switch operand; treated as quasi-static.
- Sub  in  1  subtract select; present only with ADDER_SUB_EN.
- Add_S  in  WIDTH  sum from the adder.
- Add_Cout  in  1  carry-out from the adder.
- Add_A  out  WIDTH  equals Acc.
- Add_B  out  WIDTH  equals B, or ~B in subtract mode.
- Add_Cin  out  1  0 for add, 1 in subtract mode.
- Acc  out  WIDTH  accumulator register.
- Breg  out  WIDTH  operand register.
- Cout  out  1  registered carry-out of the last add.
- Ovf  out  1  registered signed overflow of the last add.
- AddCount  out  CNT_W  number of adds since reset or the last clear.
- Busy  out  1  high while state is ADD.

## Operation
- Each button passes through a 2-FF synchronizer. The synchronizer stages and the edge-history FF all reset to 1. Consequence: a button held through reset release produces no edge.
- States:
  - IDLE: a Run rising edge moves to ADD. Otherwise, synced Load writes B<=SW and synced ClearA writes Acc<=0 and AddCount<=0; both may act in the same cycle.
  - ADD (exactly one cycle): Acc<=Add_S and Cout<=Add_Cout. Ovf<=(Add_A[W-1]==Add_B[W-1]) && (Add_S[W-1]!=Add_A[W-1]). AddCount<=AddCount+1, wrapping modulo 2^CNT_W. Next state is HOLD.
  - HOLD: stays until synced Run is 0, then goes to IDLE. Load and ClearA are ignored.
- Priority in IDLE: a Run edge beats Load and ClearA in the same cycle; those are ignored for that cycle only and re-act next cycle if still held.
- Arithmetic is modulo 2^WIDTH. Cout reports unsigned carry, or no-borrow when subtracting; Ovf reports two's-complement overflow.
- Load, ClearA and Sub are ignored outside IDLE, so operands cannot change mid-add.
- Reset (asynchronous, any state, including mid-ADD):
  - state=IDLE;
  - Acc, Breg, AddCount, Cout, Ovf all 0;
  - Busy=0;
  - Add_B=0 and Add_Cin=0.

## Timing
- Run rising at the pin to Busy high: 3 Clk edges (2 synchronizer stages plus edge detect).
- Acc is updated on the edge that ends ADD, one cycle after Busy rises.
- Add_A, Add_B and Add_Cin are stable for the whole ADD cycle. The adder path is combinational within that cycle; no multicycle path is needed.
- Each Run press yields exactly one add regardless of how long it is held. Run pulses shorter than 2 Clk periods may be missed; that is acceptable.
- Load takes effect 3 edges after assertion at the pin and keeps rewriting B each IDLE cycle while held.

## Configuration
- ADDER_SUB_EN defined:
  - The Sub port exists and is sampled into a mode FF when IDLE moves to ADD.
  - In ADD with mode=1, Add_B=~Breg and Add_Cin=1, so Acc<=Acc-Breg.
  - Ovf is computed on the effective Add_B.
- ADDER_SUB_EN undefined:
  - No Sub port and no mode FF.
  - Add_B=Breg and Add_Cin=0 permanently.

## Structure
- Package adder_ctrl_pkg holds: the state enum (IDLE, ADD, HOLD), the WIDTH and CNT_W defaults, and the synchronizer reset value (1'b1).
- Sub-module button_sync provides the 2-FF synchronizer, rising-edge output and level output, with a reset-value parameter. It is instantiated three times.
- The adder itself is instantiated at the level above and connected via the Add_* ports.

## Test plan
- Reset mid-ADD, with Acc previously 0x1234 -> Acc=0, Busy=0, state IDLE, AddCount=0, all asynchronously.
- Load with SW=0x0001, ClearA, then Run x3 -> Acc=0x0003, AddCount=3. Run held for 50 cycles counts as a single add.
- Acc=0x7FFF, B=0x0001, Run -> Acc=0x8000, Ovf=1, Cout=0. Acc=0xFFFF, B=0x0001, Run -> Acc=0x0000, Cout=1, Ovf=0.
- Run held through reset release -> no add. After release then press -> one add, 3 cycles to Busy.
- Run edge and Load arriving in the same synced cycle, SW=0x00FF, B=0x0002 -> add uses 0x0002; B becomes 0x00FF on the cycle after HOLD exits if Load is still held.
- ADDER_SUB_EN: Acc=0x0005, B=0x0007, Sub=1, Run -> Acc=0xFFFE, Cout=0, Ovf=0. AddCount wraps from 0xFF to 0x00 after 256 adds.
